gol_scan_driver: RTL and testbench

Reads the 64-cell generation grid produced by the Game of Life datapath and drives an 8x8 LED matrix by row multiplexing. A generation is accepted over a valid/ack handshake into a pending buffer. It is promoted to the display buffer only at a frame boundary, so the panel never shows a torn generation. The block sits between the datapath's `grid` output and the board's row/column pins.

---
 rtl/gol_pkg.sv | 10 +
 rtl/gol_scan_driver_if.sv | 15 +
 rtl/gol_dwell_timer.sv | 17 +
 rtl/gol_scan_driver.sv | 78 +++++++
 tb/tb_gol_scan_driver.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: shared grid geometry, scan state encoding and cell index mapping
package gol_pkg;
   localparam int GRID_W = 64;
   localparam int ROWS = 8;
   localparam int COLS = 8;
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
   function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
      return {r, c};
   endfunction
endpackage

// File: rtl/gol_scan_driver_if.sv
// gol_scan_driver_if: generation handshake and LED panel pins of the scan driver
interface gol_scan_driver_if;
   import gol_pkg::*;
   logic en;
   logic [GRID_W-1:0] grid_in;
   logic grid_valid;
   logic grid_ack;
   logic overrun;
   logic [ROWS-1:0] row_n;
   logic [COLS-1:0] col;
   logic [2:0] row_idx;
   logic frame_done;
   modport master(output en, grid_in, grid_valid, input grid_ack, overrun, row_n, col, row_idx, frame_done);
   modport slave(input en, grid_in, grid_valid, output grid_ack, overrun, row_n, col, row_idx, frame_done);
endinterface

// File: rtl/gol_dwell_timer.sv
// gol_dwell_timer: loadable down-counter that parks at zero and flags terminal count
module gol_dwell_timer #(parameter int CW = 4) (
   input logic clka,
   input logic stop,
   input logic ld,
   input logic [CW-1:0] ld_val,
   output logic [CW-1:0] cnt,
   output logic tc
);
   // reload on state entry, otherwise count down to zero and hold
   always_ff @(posedge clka) begin
      if (stop) cnt <= '0;
      else if (ld) cnt <= ld_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end
   assign tc = cnt == '0;
endmodule

// File: rtl/gol_scan_driver.sv
// gol_scan_driver: double-buffered row-multiplexed 8x8 LED scan of a Game of Life grid
module gol_scan_driver
   import gol_pkg::*;
#(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input logic clka,
   input logic stop,
   gol_scan_driver_if.slave bus
);
   localparam int CW = $clog2(DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1;
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
   scan_state_t state, state_nxt;
   logic [2:0] row, row_nxt;
   logic [GRID_W-1:0] pend, disp;
   logic pend_full, ld, start, promote, last_nxt, tc;
   logic [CW-1:0] ld_val, cnt;
   gol_dwell_timer #(.CW(CW)) u_timer (.clka(clka), .stop(stop), .ld(ld), .ld_val(ld_val), .cnt(cnt), .tc(tc));
   // next scan position; every state entry reloads the timer, row 0 BLANK entry is a frame start
   always_comb begin
      state_nxt = state;
      row_nxt = row;
      ld = 1'b0;
      ld_val = BLANK_LD;
      start = 1'b0;
      if (!bus.en) begin
         state_nxt = IDLE;
         row_nxt = 3'd0;
         ld = 1'b1;
      end else if (state == IDLE) begin
         state_nxt = BLANK;
         row_nxt = 3'd0;
         ld = 1'b1;
         start = 1'b1;
      end else if (tc) begin
         ld = 1'b1;
         if (state == BLANK) begin
            state_nxt = SHOW;
            ld_val = DWELL_LD;
         end else begin
            state_nxt = BLANK;
            row_nxt = row + 3'd1;
            start = row == 3'd7;
         end
      end
   end
   assign promote = start & pend_full;
   assign last_nxt = state_nxt == SHOW && row_nxt == 3'd7 && (ld ? ld_val == '0 : cnt == CW'(1));
   assign bus.row_idx = row;
   // scan state, generation buffers and registered panel outputs
   always_ff @(posedge clka) begin
      if (stop) begin
         state <= IDLE;
         row <= 3'd0;
         pend <= '0;
         disp <= '0;
         pend_full <= 1'b0;
         bus.grid_ack <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.overrun <= 1'b0;
         bus.row_n <= '1;
         bus.col <= '0;
      end else begin
         state <= state_nxt;
         row <= row_nxt;
         if (promote) disp <= pend;
         if (bus.grid_valid) pend <= bus.grid_in;
         pend_full <= bus.grid_valid | (pend_full & ~promote);
         bus.overrun <= bus.overrun | (bus.grid_valid & pend_full & ~promote);
         bus.grid_ack <= promote;
         bus.frame_done <= last_nxt;
         bus.row_n <= state_nxt == SHOW ? ~(ROWS'(1) << row_nxt) : '1;
         bus.col <= state_nxt == SHOW ? disp[cell_idx(row_nxt, 3'd0) +: COLS] : '0;
      end
   end
endmodule

// File: tb/tb_gol_scan_driver.sv
// tb_gol_scan_driver: segment table plus hand sequences against a frame-position scoreboard
module tb_gol_scan_driver;
   import gol_pkg::*;
   localparam int DW = 4;
   localparam int BW = 1;
   localparam int RP = DW + BW;
   localparam int FP = 8 * RP;
   localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
   typedef struct packed {
      logic [7:0] row_n;
      logic [7:0] col;
      logic [2:0] row_idx;
      logic ack;
      logic fd;
      logic ovr;
   } outs_t;
   typedef struct {
      logic s;
      logic e;
      logic v;
      logic [63:0] g;
      int n;
      int acks;
      int fds;
      logic ovr;
   } seg_t;
   logic clka = 1'b0;
   logic stop = 1'b1;
   gol_scan_driver_if bus();
   gol_scan_driver #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BW)) dut (.clka(clka), .stop(stop), .bus(bus));
   always #5 clka = ~clka;
   outs_t exp_q[$];
   int compared = 0;
   int mismatched = 0;
   int ack_seen = 0;
   int fd_seen = 0;
   logic m_on = 1'b0;
   int t = 0;
   logic [63:0] m_disp = '0, m_pend = '0;
   logic m_full = 1'b0, m_ovr = 1'b0;
   seg_t segs[7];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask
   task automatic step(input logic s, input logic e, input logic v, input logic [63:0] g);
      outs_t x, a;
      logic pr;
      @(negedge clka);
      stop = s;
      bus.en = e;
      bus.grid_valid = v;
      bus.grid_in = g;
      if (s) begin
         m_on = 1'b0;
         t = 0;
         m_disp = '0;
         m_pend = '0;
         m_full = 1'b0;
         m_ovr = 1'b0;
         x = '{8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      end else begin
         pr = 1'b0;
         if (!e) m_on = 1'b0;
         else begin
            t = m_on ? (t + 1) % FP : 0;
            m_on = 1'b1;
            pr = (t == 0) && m_full;
         end
         if (v && m_full && !pr) m_ovr = 1'b1;
         if (pr) m_disp = m_pend;
         if (v) begin
            m_pend = g;
            m_full = 1'b1;
         end else if (pr) m_full = 1'b0;
         x.ovr = m_ovr;
         x.ack = pr;
         x.fd = m_on && t == FP - 1;
         x.row_idx = m_on ? 3'(t / RP) : 3'd0;
         if (m_on && t % RP >= BW) begin
            x.row_n = ~(8'd1 << x.row_idx);
            x.col = m_disp[8 * x.row_idx +: 8];
         end else begin
            x.row_n = 8'hFF;
            x.col = 8'h00;
         end
      end
      exp_q.push_back(x);
      @(posedge clka);
      #1;
      a = '{bus.row_n, bus.col, bus.row_idx, bus.grid_ack, bus.frame_done, bus.overrun};
      ack_seen += int'(a.ack);
      fd_seen += int'(a.fd);
      x = exp_q.pop_front();
      check($sformatf("outputs{row_n,col,row_idx,ack,fd,ovr} t=%0d on=%0b", t, m_on), 64'(a), 64'(x));
   endtask
   task automatic run(input int n, input logic e);
      for (int k = 0; k < n; k++) step(1'b0, e, 1'b0, 64'h0);
   endtask
   initial begin
      int a0, f0;
      bus.en = 1'b0;
      bus.grid_valid = 1'b0;
      bus.grid_in = '0;
      segs[0] = '{1'b1, 1'b0, 1'b0, 64'h0, 3, 0, 0, 1'b0};
      segs[1] = '{1'b0, 1'b1, 1'b0, 64'h0, 80, 0, 2, 1'b0};
      segs[2] = '{1'b0, 1'b0, 1'b0, 64'h0, 2, 0, 0, 1'b0};
      segs[3] = '{1'b0, 1'b0, 1'b1, 64'hFF, 1, 0, 0, 1'b0};
      segs[4] = '{1'b0, 1'b1, 1'b0, 64'h0, 40, 1, 1, 1'b0};
      segs[5] = '{1'b0, 1'b1, 1'b0, 64'h0, 15, 0, 0, 1'b0};
      segs[6] = '{1'b0, 1'b1, 1'b1, GLIDER, 25, 0, 1, 1'b0};
      foreach (segs[i]) begin
         a0 = ack_seen;
         f0 = fd_seen;
         for (int k = 0; k < segs[i].n; k++) step(segs[i].s, segs[i].e, k == 0 ? segs[i].v : 1'b0, segs[i].g);
         check($sformatf("seg%0d grid_ack count", i), 64'(ack_seen - a0), 64'(segs[i].acks));
         check($sformatf("seg%0d frame_done count", i), 64'(fd_seen - f0), 64'(segs[i].fds));
         check($sformatf("seg%0d overrun", i), 64'(bus.overrun), 64'(segs[i].ovr));
      end
      for (int k = 0; k < FP; k++) begin
         step(1'b0, 1'b1, 1'b0, 64'h0);
         if (k == 0) check("glider ack", 64'(bus.grid_ack), 64'h1);
         if (k == 1) check("glider row0 row_n", 64'(bus.row_n), 64'hFE);
         if (k == 1) check("glider row0 col", 64'(bus.col), 64'h02);
         if (k == 6) check("glider row1 col", 64'(bus.col), 64'h04);
         if (k == 11) check("glider row2 col", 64'(bus.col), 64'h07);
         if (k == 16) check("glider row3 col", 64'(bus.col), 64'h00);
      end
      a0 = ack_seen;
      step(1'b0, 1'b1, 1'b1, {32{2'b10}});
      run(9, 1'b1);
      step(1'b0, 1'b1, 1'b1, {32{2'b01}});
      check("overrun set", 64'(bus.overrun), 64'h1);
      run(29, 1'b1);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("overrun promote ack", 64'(bus.grid_ack), 64'h1);
      check("overrun single ack", 64'(ack_seen - a0), 64'h1);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("latest wins col", 64'(bus.col), 64'h55);
      step(1'b1, 1'b1, 1'b1, '1);
      check("reset clears overrun", 64'(bus.overrun), 64'h0);
      step(1'b0, 1'b0, 1'b1, 64'h81);
      step(1'b0, 1'b1, 1'b1, 64'h18);
      check("coincide ack", 64'(bus.grid_ack), 64'h1);
      check("coincide no overrun", 64'(bus.overrun), 64'h0);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("coincide old shown", 64'(bus.col), 64'h81);
      run(38, 1'b1);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("coincide second ack", 64'(bus.grid_ack), 64'h1);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("coincide new shown", 64'(bus.col), 64'h18);
      check("coincide overrun clear", 64'(bus.overrun), 64'h0);
      run(25, 1'b1);
      check("row5 show row_n", 64'(bus.row_n), 64'hDF);
      step(1'b0, 1'b0, 1'b0, 64'h0);
      check("en low blanks row_n", 64'(bus.row_n), 64'hFF);
      check("en low row_idx", 64'(bus.row_idx), 64'h0);
      run(1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("restart blank row_n", 64'(bus.row_n), 64'hFF);
      check("restart no ack", 64'(bus.grid_ack), 64'h0);
      run(3, 1'b1);
      check("restart row0 col", 64'(bus.col), 64'h18);
      step(1'b1, 1'b1, 1'b1, '1);
      check("stop outputs", {bus.row_n, bus.col, 5'(bus.row_idx), bus.grid_ack, bus.frame_done, bus.overrun}, {8'hFF, 8'h00, 5'd0, 3'b000});
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("stop drops pending", 64'(bus.grid_ack), 64'h0);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("stop clears disp", 64'(bus.col), 64'h00);
      run(2, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
